// File: rtl/mem_responder_if.sv
// Request/response bus between an initiator (master) and mem_responder (slave).
interface mem_responder_if;
    logic        reqcyc;
    logic [63:0] req;
    logic [12:0] reqtag;
    logic        reqack;
    logic        respcyc;
    logic [63:0] resp;
    logic [12:0] resptag;
    logic        respack;

    modport master (
        output reqcyc, req, reqtag, respack,
        input  reqack, respcyc, resp, resptag
    );

    modport slave (
        input  reqcyc, req, reqtag, respack,
        output reqack, respcyc, resp, resptag
    );
endinterface

// File: rtl/mem_responder.sv
// Line-burst memory responder: 8-word read bursts, 8-beat write bursts, single FSM.
// Define MEM_RESPONDER_WRITE_EN to make the backing store writable; otherwise writes are discarded.
module mem_responder #(
    parameter int MEM_WORDS    = 8192,
    parameter int READ_LATENCY = 4
) (
    input  logic           clk,
    input  logic           reset,
    mem_responder_if.slave bus
);
    localparam int          AW           = $clog2(MEM_WORDS);
    localparam int          LW           = AW - 3;
    localparam logic [3:0]  SPACE_MEMORY = 4'b0001;
    localparam logic [3:0]  LAST_WAIT    = 4'(READ_LATENCY - 1);
`ifdef MEM_RESPONDER_WRITE_EN
    localparam bit          WRITE_EN     = 1'b1;
    localparam logic [63:0] WRITE_RESP   = 64'h0;
`else
    localparam bit          WRITE_EN     = 1'b0;
    localparam logic [63:0] WRITE_RESP   = 64'hFFFF_FFFF_FFFF_FFFF;
`endif

    typedef enum logic [1:0] {IDLE, WDATA, WAIT, RESP} state_t;

    state_t        state_q,   state_d;
    logic          reqack_q,  reqack_d;
    logic          respcyc_q, respcyc_d;
    logic [63:0]   resp_q,    resp_d;
    logic [12:0]   resptag_q, resptag_d;
    logic [LW-1:0] line_q,    line_d;
    logic [2:0]    beat_q,    beat_d;
    logic [3:0]    lat_q,     lat_d;

    // Not cleared by reset, so a preloaded image survives.
    logic [63:0]   mem [MEM_WORDS];

    logic [AW-1:0] rd_idx;
    logic [AW-1:0] wr_idx;
    logic [63:0]   rd_data;
    logic          mem_we;
    logic          accept;
    logic          tag_mem;
    logic          burst;
    logic          unused_req_bits;

    // Only the line index of the address matters; the word offset and upper bits wrap away.
    assign unused_req_bits = ^{bus.req[63:AW+3], bus.req[5:0]};

    always_comb begin
        tag_mem   = (resptag_q[11:8] == SPACE_MEMORY);
        burst     = resptag_q[12] && tag_mem;
        accept    = bus.reqcyc && !reqack_q;
        rd_idx    = (state_q == WAIT) ? {line_q, 3'd0} : {line_q, beat_q + 3'd1};
        rd_data   = mem[rd_idx];
        wr_idx    = {line_q, beat_q};
        mem_we    = 1'b0;

        state_d   = state_q;
        reqack_d  = 1'b0;
        respcyc_d = respcyc_q;
        resp_d    = resp_q;
        resptag_d = resptag_q;
        line_d    = line_q;
        beat_d    = beat_q;
        lat_d     = lat_q;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    reqack_d  = 1'b1;
                    line_d    = bus.req[AW+2:6];
                    resptag_d = bus.reqtag;
                    beat_d    = 3'd0;
                    lat_d     = 4'd0;
                    state_d   = bus.reqtag[12] ? WAIT : WDATA;
                end
            end
            WDATA: begin
                if (accept) begin
                    reqack_d = 1'b1;
                    mem_we   = WRITE_EN && tag_mem;
                    beat_d   = beat_q + 3'd1;
                    if (beat_q == 3'd7) begin
                        state_d   = RESP;
                        respcyc_d = 1'b1;
                        resp_d    = tag_mem ? WRITE_RESP : 64'h0;
                    end
                end
            end
            WAIT: begin
                if (lat_q == LAST_WAIT) begin
                    state_d   = RESP;
                    respcyc_d = 1'b1;
                    resp_d    = burst ? rd_data : 64'h0;
                    beat_d    = 3'd0;
                end else begin
                    lat_d = lat_q + 4'd1;
                end
            end
            RESP: begin
                // rd_idx already points at the next word, so the following beat is ready one cycle later.
                if (bus.respack) begin
                    if (!burst || beat_q == 3'd7) begin
                        state_d   = IDLE;
                        respcyc_d = 1'b0;
                        resp_d    = 64'h0;
                        beat_d    = 3'd0;
                    end else begin
                        beat_d = beat_q + 3'd1;
                        resp_d = rd_data;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            reqack_q  <= 1'b0;
            respcyc_q <= 1'b0;
            resp_q    <= 64'h0;
            resptag_q <= 13'h0;
            line_q    <= '0;
            beat_q    <= 3'd0;
            lat_q     <= 4'd0;
        end else begin
            state_q   <= state_d;
            reqack_q  <= reqack_d;
            respcyc_q <= respcyc_d;
            resp_q    <= resp_d;
            resptag_q <= resptag_d;
            line_q    <= line_d;
            beat_q    <= beat_d;
            lat_q     <= lat_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem[wr_idx] <= bus.req;
    end

    assign bus.reqack  = reqack_q;
    assign bus.respcyc = respcyc_q;
    assign bus.resp    = resp_q;
    assign bus.resptag = resptag_q;
endmodule
